// File: rtl/pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : pipe_pkg                                                     |
// | Description : Shared RV32 pipeline constants and stage payload packings.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  // IF/ID payload packing: {pc, pc4, inst}
  localparam int IF_ID_W        = 96;
  localparam int IF_ID_INST_LSB = 0;
  localparam int IF_ID_INST_MSB = 31;
  localparam int IF_ID_PC4_LSB  = 32;
  localparam int IF_ID_PC4_MSB  = 63;
  localparam int IF_ID_PC_LSB   = 64;
  localparam int IF_ID_PC_MSB   = 95;

  localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE = {64'h0, NOP_INST};

  // Occupancy encoding as {main valid, skid valid}.
  localparam logic [1:0] OCC_EMPTY   = 2'b00;
  localparam logic [1:0] OCC_ONE     = 2'b10;
  localparam logic [1:0] OCC_FULL    = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
  } if_id_t;

  function automatic logic [IF_ID_W-1:0] if_id_pack(
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] inst
  );
    return {pc, pc + 32'd4, inst};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                               |
// | Description : Elastic pipeline-stage register with two-entry skid buffer, |
// |               flush with bubble insertion and occupancy output.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = IF_ID_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = IF_ID_BUBBLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        count_o
);

  logic              r_mv;
  logic              r_sv;
  logic [DATA_W-1:0] r_mdata;
  logic [DATA_W-1:0] r_sdata;

  logic              w_accept;
  logic              w_consume;
  logic [1:0]        w_occ;

  // Upstream ready depends only on the skid flag, so it is a pure register output.
  assign up_ready_o = ~r_sv;
  assign dn_valid_o = r_mv;
  assign dn_data_o  = r_mdata;
  assign count_o    = {1'b0, r_mv} + {1'b0, r_sv};

  assign w_accept  = up_valid_i & ~r_sv;
  assign w_consume = r_mv & dn_ready_i & ~stall_i;
  assign w_occ     = {r_mv, r_sv};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mv    <= 1'b0;
      r_sv    <= 1'b0;
      r_mdata <= BUBBLE_VAL;
      r_sdata <= BUBBLE_VAL;
    end else if (flush_i) begin
      r_mv    <= 1'b0;
      r_sv    <= 1'b0;
      r_mdata <= BUBBLE_VAL;
    end else begin
      case (w_occ)
        OCC_EMPTY: begin
          if (w_accept) begin
            r_mv    <= 1'b1;
            r_mdata <= up_data_i;
          end
        end
        OCC_ONE: begin
          if (w_accept && w_consume) begin
            r_mdata <= up_data_i;
          end else if (w_accept) begin
            r_sv    <= 1'b1;
            r_sdata <= up_data_i;
          end else if (w_consume) begin
            r_mv <= 1'b0;
          end
        end
        OCC_FULL: begin
          if (w_consume) begin
            r_mdata <= r_sdata;
            r_sv    <= 1'b0;
          end
        end
        default: begin
          // Unreachable skid-without-main state: drop back to empty.
          r_mv <= 1'b0;
          r_sv <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                            |
// | Description : Scoreboard bench for pipe_stage_reg.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int             W   = IF_ID_W;
  localparam logic [W-1:0]   BUB = IF_ID_BUBBLE;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_i;
  logic         stall_i;
  logic         up_valid_i;
  logic         up_ready_o;
  logic [W-1:0] up_data_i;
  logic         dn_valid_o;
  logic         dn_ready_i;
  logic [W-1:0] dn_data_o;
  logic [1:0]   count_o;

  pipe_stage_reg #(
    .DATA_W     (W),
    .BUBBLE_VAL (BUB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .stall_i    (stall_i),
    .up_valid_i (up_valid_i),
    .up_ready_o (up_ready_o),
    .up_data_i  (up_data_i),
    .dn_valid_o (dn_valid_o),
    .dn_ready_i (dn_ready_i),
    .dn_data_o  (dn_data_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_deliv = 0;
  logic [W-1:0] sb[$];
  bit           bubble_known = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: settle handshakes from current inputs, update the model, then
  // compare the DUT against the model 1 time unit after the edge.
  task automatic cycle(output bit acc);
    bit           con;
    logic [W-1:0] head;
    acc = (rst !== 1'b1) && up_valid_i && up_ready_o;
    con = (rst !== 1'b1) && dn_valid_o && dn_ready_i && !stall_i;
    if (rst === 1'b1) begin
      sb.delete();
      bubble_known = 1'b1;
    end else begin
      if (con) begin
        check("deliver_nonempty", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
          head = sb.pop_front();
          check("deliver_data", dn_data_o, head);
          n_deliv++;
        end
      end
      if (flush_i) begin
        sb.delete();
        bubble_known = 1'b1;
      end else if (acc) begin
        sb.push_back(up_data_i);
        bubble_known = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("count", W'(count_o), W'(sb.size()));
    check("dn_valid", W'(dn_valid_o), W'(sb.size() != 0));
    check("up_ready", W'(up_ready_o), W'(sb.size() < 2));
    check("legal_state", W'(dn_valid_o || up_ready_o), W'(1));
    if (sb.size() != 0)     check("dn_data_head", dn_data_o, sb[0]);
    else if (bubble_known)  check("dn_data_bubble", dn_data_o, BUB);
  endtask

  initial begin
    bit acc;
    int sent;
    int base;
    int cyc;

    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    up_valid_i = 1'b1; up_data_i = if_id_pack(32'h1000, 32'hDEAD_0001);
    dn_ready_i = 1'b1;

    // Reset held two cycles while upstream offers a beat.
    cycle(acc);
    cycle(acc);
    check("rst_count", W'(count_o), W'(0));
    check("rst_data", dn_data_o, BUB);
    rst = 1'b0;
    up_valid_i = 1'b0;
    cycle(acc);

    // Streaming: 8 back-to-back beats.
    up_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      up_data_i = if_id_pack(32'h2000 + 32'(4 * k), 32'h0000_0100 + 32'(k));
      cycle(acc);
      check("stream_count", W'(count_o), W'(1));
      check("stream_inst", W'(dn_data_o[IF_ID_INST_MSB:IF_ID_INST_LSB]), W'(32'h0000_0100 + 32'(k)));
    end
    up_valid_i = 1'b0;
    cycle(acc);

    // Skid fill/drain: A in main, B into skid under stall, C held.
    up_valid_i = 1'b1; up_data_i = if_id_pack(32'h3000, 32'hA);
    cycle(acc);
    stall_i = 1'b1; up_data_i = if_id_pack(32'h3004, 32'hB);
    cycle(acc);
    check("skid_ready_low", W'(up_ready_o), W'(0));
    up_data_i = if_id_pack(32'h3008, 32'hC);
    cycle(acc);
    cycle(acc);
    check("skid_count_full", W'(count_o), W'(2));
    stall_i = 1'b0;
    cycle(acc);
    check("drain_b", W'(dn_data_o[IF_ID_INST_MSB:IF_ID_INST_LSB]), W'(32'hB));
    cycle(acc);
    check("drain_c", W'(dn_data_o[IF_ID_INST_MSB:IF_ID_INST_LSB]), W'(32'hC));
    up_valid_i = 1'b0;
    cycle(acc);
    cycle(acc);

    // Flush with A main, B skid and D offered.
    up_valid_i = 1'b1; up_data_i = if_id_pack(32'h4000, 32'hA);
    cycle(acc);
    stall_i = 1'b1; up_data_i = if_id_pack(32'h4004, 32'hB);
    cycle(acc);
    up_data_i = if_id_pack(32'h4008, 32'hD);
    flush_i = 1'b1;
    cycle(acc);
    flush_i = 1'b0; up_valid_i = 1'b0; stall_i = 1'b0;
    check("flush_inst", W'(dn_data_o[IF_ID_INST_MSB:IF_ID_INST_LSB]), W'(NOP_INST));
    check("flush_valid", W'(dn_valid_o), W'(0));
    cycle(acc);
    cycle(acc);

    // Reset and flush together.
    up_valid_i = 1'b1; up_data_i = if_id_pack(32'h5000, 32'hE);
    cycle(acc);
    up_valid_i = 1'b0; rst = 1'b1; flush_i = 1'b1;
    cycle(acc);
    rst = 1'b0; flush_i = 1'b0;
    check("rstflush_ready", W'(up_ready_o), W'(1));
    cycle(acc);

    // Consume plus accept at count 1 replaces main.
    up_valid_i = 1'b1; up_data_i = if_id_pack(32'h6000, 32'hF);
    cycle(acc);
    up_data_i = if_id_pack(32'h6004, 32'h6);
    cycle(acc);
    check("replace_count", W'(count_o), W'(1));
    check("replace_inst", W'(dn_data_o[IF_ID_INST_MSB:IF_ID_INST_LSB]), W'(32'h6));
    up_valid_i = 1'b0;
    cycle(acc);

    // Randomised backpressure: 1000 beats, data held until accepted.
    base = n_deliv;
    sent = 0;
    acc  = 1'b0;
    cyc  = 0;
    while ((n_deliv - base) < 1000 && cyc < 20000) begin
      if (!up_valid_i || acc) begin
        if (sent < 1000 && $urandom_range(0, 99) < 70) begin
          up_valid_i = 1'b1;
          up_data_i  = if_id_pack($urandom, 32'h0010_0000 + 32'(sent));
          sent++;
        end else begin
          up_valid_i = 1'b0;
        end
      end
      dn_ready_i = ($urandom_range(0, 99) < 70);
      stall_i    = ($urandom_range(0, 99) < 20);
      cycle(acc);
      cyc++;
    end
    check("random_delivered", W'(n_deliv - base), W'(1000));
    check("random_drained", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
